// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between ICache line
// reads and DCache line reads/writes, with in-flight read tracking.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_wready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int          KW       = $clog2(LINE_WORDS);
  localparam int          OFF      = KW + 2;
  localparam logic [31:0] LOW_MASK = (32'd1 << OFF) - 32'd1;
  localparam logic [KW-1:0] LAST_K = '1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_ISSUE = 2'd1;
  localparam logic [1:0] S_RD_DRAIN = 2'd2;
  localparam logic [1:0] S_WR       = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]         state;
  logic [KW-1:0]      k;
  logic [31:0]        base;
  logic               owner;
  logic               last_owner;
  logic               gnt_p0;
  logic [MEM_LAT-1:0] vld_p;
  logic [MEM_LAT-1:0] own_p;
  logic [MEM_LAT-1:0] last_p;

  logic        last_word;
  logic        pick_d;
  logic        ret_vld;
  logic        ret_own;
  logic        ret_last;
  logic        issue;
  logic        wr;
  logic [31:0] sel_addr;

  assign last_word = (k == LAST_K);
  // On a tie, ICache wins only if DCache owned the previous transaction.
  assign pick_d    = d_req && !(i_req && (last_owner == OWN_D));
  assign sel_addr  = pick_d ? d_addr : i_addr;
  assign ret_vld   = vld_p[MEM_LAT-1];
  assign ret_own   = own_p[MEM_LAT-1];
  assign ret_last  = last_p[MEM_LAT-1];
  assign issue     = (state == S_RD_ISSUE);
  assign wr        = (state == S_WR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      k          <= '0;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      gnt_p0     <= 1'b0;
      vld_p      <= '0;
      own_p      <= '0;
      last_p     <= '0;
    end else begin
      gnt_p0    <= 1'b0;
      // Return tracker: entry i emerges MEM_LAT cycles after its issue.
      vld_p[0]  <= issue;
      own_p[0]  <= owner;
      last_p[0] <= last_word;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_p[i]  <= vld_p[i-1];
        own_p[i]  <= own_p[i-1];
        last_p[i] <= last_p[i-1];
      end
      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner      <= pick_d;
            last_owner <= pick_d;
            gnt_p0     <= 1'b1;
            k          <= '0;
            state      <= (pick_d && d_we) ? S_WR : S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          k <= k + KW'(1);
          if (last_word) state <= S_RD_DRAIN;
        end
        S_RD_DRAIN: begin
          if (ret_vld && ret_last) state <= S_IDLE;
        end
        default: begin
          k <= k + KW'(1);
          if (last_word) state <= S_IDLE;
        end
      endcase
    end
  end

  // Line base is pure data; only meaningful once a grant has been taken.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) base <= sel_addr & ~LOW_MASK;
  end

  always_comb begin
    mem_addr  = (issue || wr) ? (base | {{(32-OFF){1'b0}}, k, 2'b00}) : 32'd0;
    mem_we    = wr;
    mem_wdata = wr ? d_wdata : 32'd0;
    d_wready  = wr;
    i_gnt     = gnt_p0 && (owner == OWN_I);
    d_gnt     = gnt_p0 && (owner == OWN_D);
    i_rvalid  = ret_vld && (ret_own == OWN_I);
    d_rvalid  = ret_vld && (ret_own == OWN_D);
    i_rdata   = i_rvalid ? mem_rdata : 32'd0;
    d_rdata   = d_rvalid ? mem_rdata : 32'd0;
    i_done    = i_rvalid && ret_last;
    d_done    = (d_rvalid && ret_last) || (wr && last_word);
    busy      = (state != S_IDLE) || (|vld_p);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: default build plus an 8-word, 1-latency build.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid, d_done, busy, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  logic        b_i_req;
  logic [31:0] b_i_addr, b_mem_rdata;
  logic        b_i_gnt, b_i_rvalid, b_i_done, b_d_gnt, b_d_wready, b_d_rvalid, b_d_done;
  logic        b_busy, b_mem_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_wready(d_wready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_done(d_done), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  cache_mem_arbiter #(.LINE_WORDS(8), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid),
    .i_rdata(b_i_rdata), .i_done(b_i_done),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_gnt(b_d_gnt), .d_wready(b_d_wready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .d_done(b_d_done), .busy(b_busy),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata)
  );

  // Memories return the word address as data after their latency.
  logic [31:0] pipe0 = 32'd0, pipe1 = 32'd0, b_pipe = 32'd0;
  always @(posedge clk) begin
    pipe0  <= mem_addr;
    pipe1  <= pipe0;
    b_pipe <= b_mem_addr;
  end
  assign mem_rdata   = pipe1;
  assign b_mem_rdata = b_pipe;

  // DCache write source: word k of the line is 0xA0+k.
  logic [31:0] wk = 32'd0;
  always @(posedge clk) begin
    if (d_wready) wk <= d_done ? 32'd0 : wk + 32'd1;
  end
  assign d_wdata = 32'hA0 + wk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dg1, dd1, ig1, id1, dg2, both, nrv, err, bad;
    logic [31:0] last_data;
    rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0;
    b_i_req = 0; b_i_addr = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_gnt", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_done, d_done, mem_we}), 32'd0);
    rst = 1'b1;

    // Single ICache read of line 0x1000
    @(negedge clk); i_req = 1; i_addr = 32'h0000_1008;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("rd_addr", mem_addr, (c <= 4) ? 32'h1000 + 32'(4 * (c - 1)) : 32'd0);
      chk("rd_gnt", 32'(i_gnt), 32'(c == 1));
      chk("rd_rvalid", 32'(i_rvalid), 32'(c >= 3 && c <= 6));
      chk("rd_rdata", i_rdata, (c >= 3 && c <= 6) ? 32'h1000 + 32'(4 * (c - 3)) : 32'd0);
      chk("rd_done", 32'(i_done), 32'(c == 6));
      chk("rd_busy", 32'(busy), 32'(c <= 6));
      if (c == 6) i_req = 0;
    end

    // DCache line write to 0x2000
    @(negedge clk); d_req = 1; d_we = 1; d_addr = 32'h2000;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("wr_we", 32'(mem_we), 32'(c <= 4));
      chk("wr_addr", mem_addr, (c <= 4) ? 32'h2000 + 32'(4 * (c - 1)) : 32'd0);
      chk("wr_data", mem_wdata, (c <= 4) ? 32'hA0 + 32'(c - 1) : 32'd0);
      chk("wr_wready", 32'(d_wready), 32'(c <= 4));
      chk("wr_done", 32'(d_done), 32'(c == 4));
      chk("wr_gnt", 32'(d_gnt), 32'(c == 1));
      chk("wr_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
      if (c == 4) begin d_req = 0; d_we = 0; end
    end

    // Tie after reset: D, then I at done+2, then D again
    rst = 0; @(negedge clk); @(negedge clk); rst = 1;
    i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h4000; d_addr = 32'h3000;
    dg1 = -1; dd1 = -1; ig1 = -1; id1 = -1; dg2 = -1; both = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if ((i_gnt && d_gnt) || (i_done && d_done)) both++;
      if (i_gnt && ig1 < 0) ig1 = c;
      if (i_done && id1 < 0) id1 = c;
      if (d_done && dd1 < 0) dd1 = c;
      if (d_gnt) begin
        if (dg1 < 0) dg1 = c; else if (dg2 < 0) dg2 = c;
      end
      if (d_done && dg2 >= 0) begin i_req = 0; d_req = 0; end
    end
    chk("tie_dgnt1", 32'(dg1), 32'd1);
    chk("tie_ddone1", 32'(dd1), 32'd6);
    chk("tie_ignt", 32'(ig1), 32'd8);
    chk("tie_idone", 32'(id1), 32'd13);
    chk("tie_dgnt2", 32'(dg2), 32'd15);
    chk("tie_both", 32'(both), 32'd0);

    // d_req dropped mid-burst; a new i_req waits for completion
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 32'h5004;
    nrv = 0; err = 0; dd1 = -1; ig1 = -1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (d_rvalid) begin
        if (d_rdata !== 32'h5000 + 32'(4 * nrv)) err++;
        nrv++;
      end
      if (d_done && dd1 < 0) dd1 = c;
      if (i_gnt && ig1 < 0) ig1 = c;
      if (i_done) i_req = 0;
      if (c == 2) begin d_req = 0; i_req = 1; i_addr = 32'h5100; end
    end
    chk("drop_nrv", 32'(nrv), 32'd4);
    chk("drop_data", 32'(err), 32'd0);
    chk("drop_done", 32'(dd1), 32'd6);
    chk("drop_ignt", 32'(ig1), 32'd8);

    // Reset in the middle of an ICache read
    @(negedge clk); i_req = 1; i_addr = 32'h6000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("rst_mid_addr", mem_addr, 32'h6000 + 32'(4 * (c - 1)));
    end
    chk("rst_mid_rv0", 32'(i_rvalid), 32'd1);
    rst = 0; i_req = 0;
    bad = 0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      if (c == 4) rst = 1;
      if (i_rvalid || i_done || busy || mem_we || (mem_addr != 32'd0)) bad++;
    end
    chk("rst_mid_quiet", 32'(bad), 32'd0);
    @(negedge clk); i_req = 1; i_addr = 32'h6004;
    id1 = -1; last_data = 32'd0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (i_done && id1 < 0) begin id1 = c; last_data = i_rdata; i_req = 0; end
    end
    chk("post_rst_done", 32'(id1), 32'd6);
    chk("post_rst_data", last_data, 32'h600C);

    // 8-word line, single-cycle memory
    @(negedge clk); b_i_req = 1; b_i_addr = 32'h7010;
    nrv = 0; err = 0; id1 = -1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (b_i_rvalid) begin
        if (b_i_rdata !== 32'h7000 + 32'(4 * nrv)) err++;
        nrv++;
      end
      if (b_i_done && id1 < 0) begin id1 = c; b_i_req = 0; end
    end
    chk("l8_nrv", 32'(nrv), 32'd8);
    chk("l8_data", 32'(err), 32'd0);
    chk("l8_done", 32'(id1), 32'd9);
    chk("l8_busy", 32'(b_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single data-side memory port between the instruction-cache refill path and the data-cache refill/write-back path of the pipelined CPU. Each transaction is one line burst:
- an instruction line read, or
- a data line read or write.

The block arbitrates simultaneous requests round-robin, sequences word addresses, and tracks in-flight read returns through a fixed-latency memory. It returns data and a completion pulse to the owning cache. It sits between the ICache/DCache controllers and the Memory module; the caches hold their stall outputs until they receive the done pulse.

## Interface
Parameters:
- LINE_WORDS, 4: words per burst; power of two, ≥2.
- MEM_LAT, 2: cycles from mem_addr presented to mem_rdata valid; ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- i_req  in  1  ICache line-read request; level, held until i_done.
- i_addr  in  32  ICache line address; low log2(LINE_WORDS)+2 bits ignored.
- i_gnt  out  1  one-cycle pulse: ICache transaction started.
- i_rvalid  out  1  i_rdata holds a returned word.
- i_rdata  out  32  returned word, in ascending address order.
- i_done  out  1  one-cycle pulse coincident with the last i_rvalid.
- d_req  in  1  DCache request; level, held until d_done.
- d_we  in  1  1 = line write, 0 = line read; sampled with d_req at grant.
- d_addr  in  32  DCache line address; low bits ignored as for i_addr.
- d_wdata  in  32  write word k, valid in the cycle d_wready is high for word k.
- d_gnt  out  1  one-cycle pulse: DCache transaction started.
- d_wready  out  1  d_wdata consumed this cycle.
- d_rvalid  out  1  d_rdata holds a returned word.
- d_rdata  out  32  returned word.
- d_done  out  1  one-cycle pulse at end of DCache transaction.
- busy  out  1  state ≠ IDLE or reads in flight.
- mem_addr  out  32  word address to memory.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory read data, MEM_LAT cycles after mem_addr.

## Operation
- State machine has four states: IDLE, RD_ISSUE, RD_DRAIN and WR.
- **IDLE arbitration:**
  - Only one request high: grant it.
  - Both high: grant the requester not granted last.
  - The last-owner flag resets to ICache, so DCache wins the first tie.
  - On grant, latch the line base (address with the low bits zeroed), the owner, and d_we. Assert the matching gnt in the next cycle, which is the first cycle of the new state.
- **RD_ISSUE** lasts LINE_WORDS cycles:
  - Word counter k runs 0..LINE_WORDS-1.
  - mem_addr = base + 4k; mem_we = 0.
  - Each issue pushes (valid, owner) into a MEM_LAT-deep shift register.
  - After k = LINE_WORDS-1, go to RD_DRAIN.
- **RD_DRAIN:** wait until the last shift-register entry emerges, then go to IDLE.
- **Read return:** when a shift-register entry emerges, assert the owner's rvalid. The owner's rdata = mem_rdata. done is asserted with the word-(LINE_WORDS-1) return.
- **WR** lasts LINE_WORDS cycles (ICache never writes):
  - mem_we = 1, mem_addr = base + 4k, mem_wdata = d_wdata, d_wready = 1.
  - d_done is asserted in the cycle of word LINE_WORDS-1; then go to IDLE.
- Address arithmetic is 32-bit modulo and is never carried past the line: the line-offset bits come from k only.
- Requests are not re-sampled mid-transaction:
  - Dropping req early does not abort; the transaction completes.
  - A new request is considered only in IDLE.
- Idle outputs: mem_addr = 0, mem_wdata = 0, mem_we = 0; all gnt/rvalid/done/wready = 0; rdata outputs = 0 when their rvalid is low.

## Timing
- **Reset (rst = 0 at an edge):**
  - Go to IDLE and clear the shift register, which discards in-flight reads.
  - Counter = 0, last-owner = ICache.
  - All outputs = 0 the cycle after.
  - Reset mid-burst produces no further rvalid, done or mem_we.
- **Read, request seen in IDLE in cycle T:**
  - gnt at T+1.
  - mem_addr word k at T+1+k.
  - rvalid word k at T+1+k+MEM_LAT.
  - done at T+LINE_WORDS+MEM_LAT; defaults give T+6.
- **Write, request seen in cycle T:**
  - gnt and word 0 at T+1; word k at T+1+k.
  - d_done at T+LINE_WORDS; default T+4.
- State is IDLE in the cycle after done. The earliest next gnt is done+2.
- busy is high from the gnt cycle through the done cycle inclusive.
- gnt, done and wready are never asserted for both owners in the same cycle.

## Test plan
- Single ICache read, i_addr = 0x0000_1008, mem_rdata = addr:
  - mem_addr 0x1000, 0x1004, 0x1008, 0x100C at T+1..T+4.
  - i_rvalid with data 0x1000..0x100C at T+3..T+6.
  - i_done at T+6.
- DCache write, d_addr = 0x2000, d_wdata = 0xA0+k:
  - mem_we high T+1..T+4; addresses 0x2000..0x200C; data 0xA0..0xA3.
  - d_done at T+4; no rvalid.
- Simultaneous i_req and d_req after reset:
  - d_gnt first; i_gnt follows at d_done+2.
  - Repeat the tie: i_gnt first, i.e. round-robin alternation.
- d_req deasserted at T+2 during a read burst:
  - All 4 d_rvalid and d_done are still produced.
  - A new i_req is granted only afterwards.
- rst = 0 at T+3 of an ICache read:
  - No i_rvalid or i_done after T+3; busy = 0 and mem_addr = 0 from T+4.
  - A fresh request after reset completes normally.
- MEM_LAT = 1 and LINE_WORDS = 8 read: i_done at T+9 with 8 ascending words.
